// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared run states, halt encoding and LEGv8 branch field/opcode constants
package instruction_fetch_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   localparam logic [31:0] HLT_ENC = 32'hD4400000;
   localparam int IMM26_HI = 25;
   localparam int IMM26_LO = 0;
   localparam int IMM19_HI = 23;
   localparam int IMM19_LO = 5;
   localparam logic [5:0] OP_B = 6'b000101;
   localparam logic [7:0] OP_CBNZ = 8'b10110101;
endpackage

// File: rtl/instruction_fetch_instr_mem.sv
// instr_mem: word-addressed instruction store, synchronous write, asynchronous read
module instr_mem #(
   parameter int DEPTH = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);
   logic [31:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, instruction memory, next-PC selection and IDLE/RUN/HALT run control
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int          DEPTH = 256,
   parameter int          ADDR_W = 8,
   parameter logic [31:0] HALT_WORD = HLT_ENC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   input  logic              Branch,
   input  logic              UncondBranch,
   input  logic              Zero,
   output logic [31:0]       Instruction,
   output logic [63:0]       PC,
   output logic              running,
   output logic              halted,
   output logic              fault,
   output logic [31:0]       retired
);
   localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd4;
   state_t      state;
   logic [31:0] rd;
   logic [63:0] offset, next_pc;
   logic        taken, oor;
   instr_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clk(clk),
      .we(rst_n && load_en && state == IDLE),
      .waddr(load_addr),
      .wdata(load_data),
      .raddr(PC[ADDR_W+1:2]),
      .rdata(rd)
   );
   assign Instruction = state == RUN ? rd : 32'h0;
   assign running = state == RUN;
   assign halted = state == HALT;
   always_comb begin
      offset = UncondBranch ? {{36{Instruction[IMM26_HI]}}, Instruction[IMM26_HI:IMM26_LO], 2'b00}
                            : {{43{Instruction[IMM19_HI]}}, Instruction[IMM19_HI:IMM19_LO], 2'b00};
      taken = UncondBranch | (Branch & ~Zero);
      next_pc = taken ? PC + offset : PC + 64'd4;
      oor = next_pc >= LIMIT;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         PC <= '0;
         retired <= '0;
         fault <= 1'b0;
      end else if (state == RUN) begin
         if (Instruction != HALT_WORD) begin
            retired <= retired + {31'b0, ~&retired};
            if (oor) fault <= 1'b1;
            else PC <= next_pc;
         end
         if (Instruction == HALT_WORD || oor) state <= HALT;
      end else if (start) begin
         state <= RUN;
         PC <= '0;
         retired <= '0;
         fault <= 1'b0;
      end
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plan checks plus randomized run against a behavioural fetch model
module tb_instruction_fetch;
   localparam logic [31:0] HLT = 32'hD4400000;
   localparam logic [31:0] ADD = 32'h8B030041;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
   logic clk = 0, rst_n = 0, start = 0, load_en = 0, Branch = 0, UncondBranch = 0, Zero = 0;
   logic [7:0] load_addr = 0;
   logic [31:0] load_data = 0, Instruction, retired;
   logic [63:0] PC;
   logic running, halted, fault;
   int n_chk = 0, n_err = 0;
   logic [31:0] m_mem [256];
   int m_st = M_IDLE;
   logic [63:0] m_pc = 0;
   logic [31:0] m_ret = 0;
   logic m_flt = 0;

   instruction_fetch dut (
      .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .Branch(Branch), .UncondBranch(UncondBranch), .Zero(Zero),
      .Instruction(Instruction), .PC(PC), .running(running), .halted(halted),
      .fault(fault), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] b_ins(input int imm);
      logic [25:0] f = 26'(imm);
      return {6'b000101, f};
   endfunction

   function automatic logic [31:0] cbnz_ins(input int imm);
      logic [18:0] f = 19'(imm);
      return {8'b10110101, f, 5'd3};
   endfunction

   function automatic logic [31:0] rand_ins();
      case ($urandom % 8)
         0, 1, 2: return ADD;
         3: return b_ins(int'($urandom_range(0, 16)) - 8);
         4: return cbnz_ins(int'($urandom_range(0, 16)) - 8);
         5: return HLT;
         6: return b_ins(int'($urandom));
         default: return $urandom;
      endcase
   endfunction

   // Compare current outputs against the model, then advance it with the inputs the next edge will see.
   always @(negedge clk) begin
      logic [31:0] ins;
      logic [63:0] off, tgt;
      ins = m_st == M_RUN ? m_mem[(m_pc >> 2) % 256] : 32'h0;
      check("cyc_instruction", Instruction, ins);
      check("cyc_pc", PC, m_pc);
      check("cyc_running", running, m_st == M_RUN);
      check("cyc_halted", halted, m_st == M_HALT);
      check("cyc_fault", fault, m_flt);
      check("cyc_retired", retired, m_ret);
      if (!rst_n) begin
         m_st = M_IDLE; m_pc = 0; m_ret = 0; m_flt = 0;
      end else if (m_st == M_IDLE) begin
         if (load_en) m_mem[load_addr] = load_data;
         if (start) begin m_st = M_RUN; m_pc = 0; m_ret = 0; m_flt = 0; end
      end else if (m_st == M_HALT) begin
         if (start) begin m_st = M_RUN; m_pc = 0; m_ret = 0; m_flt = 0; end
      end else if (ins == HLT) begin
         m_st = M_HALT;
      end else begin
         off = UncondBranch ? 64'(longint'($signed({ins[25:0], 2'b00})))
                            : 64'(longint'($signed({ins[23:5], 2'b00})));
         tgt = (UncondBranch || (Branch && !Zero)) ? m_pc + off : m_pc + 64'd4;
         if (m_ret != 32'hFFFFFFFF) m_ret = m_ret + 1;
         if (tgt >= 64'd1024) begin m_st = M_HALT; m_flt = 1; end
         else m_pc = tgt;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 0; start = 0; load_en = 0; Branch = 0; UncondBranch = 0; Zero = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic ld(input int a, input logic [31:0] d);
      load_en = 1; load_addr = 8'(a); load_data = d;
      tick();
      load_en = 0;
   endtask

   task automatic go();
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic cbnz_case(input string name, input logic br, input logic z, input logic [63:0] exp);
      do_reset();
      go();
      tick();
      Branch = br; Zero = z;
      tick();
      check(name, PC, exp);
      Branch = 0; Zero = 0;
      tick(2);
   endtask

   initial begin
      tick(2);
      check("rst_pc", PC, 0);
      check("rst_running", running, 0);
      check("rst_retired", retired, 0);
      check("rst_instruction", Instruction, 0);
      rst_n = 1;
      for (int i = 0; i < 256; i++) ld(i, ADD);
      ld(2, HLT);
      go();
      check("p1_pc0", PC, 0);
      check("p1_running", running, 1);
      tick();
      check("p1_pc4", PC, 4);
      tick();
      check("p1_pc8", PC, 8);
      tick();
      check("p1_halted", halted, 1);
      check("p1_pc_hold", PC, 8);
      check("p1_retired", retired, 2);
      check("p1_fault", fault, 0);

      do_reset();
      ld(0, b_ins(3)); ld(3, b_ins(-1)); ld(2, b_ins(-1)); ld(1, HLT);
      UncondBranch = 1;
      go();
      tick();
      check("b_fwd_pc", PC, 12);
      check("b_fwd_retired", retired, 1);
      tick(2);
      check("b_back_pc", PC, 4);
      check("b_halt_instr", Instruction, HLT);
      tick();
      check("b_halted", halted, 1);
      check("b_retired", retired, 3);

      do_reset();
      ld(0, ADD); ld(1, cbnz_ins(2)); ld(2, HLT); ld(3, HLT);
      cbnz_case("cbnz_taken", 1, 0, 12);
      cbnz_case("cbnz_zero", 1, 1, 8);
      cbnz_case("cbnz_nobranch", 0, 1'($urandom), 8);

      do_reset();
      ld(0, b_ins(256));
      UncondBranch = 1;
      go();
      tick();
      check("oor_halted", halted, 1);
      check("oor_fault", fault, 1);
      check("oor_pc", PC, 0);
      check("oor_retired", retired, 1);
      go();
      check("restart_pc", PC, 0);
      check("restart_fault", fault, 0);
      check("restart_running", running, 1);

      do_reset();
      load_en = 1; load_addr = 0; load_data = HLT; start = 1;
      tick();
      load_en = 0; start = 0;
      check("ldst_instr", Instruction, HLT);
      tick();
      check("ldst_halted", halted, 1);
      check("ldst_retired", retired, 0);

      do_reset();
      for (int i = 0; i < 5; i++) ld(i, ADD);
      ld(5, HLT);
      go();
      load_en = 1; load_addr = 3; load_data = HLT;
      tick(4);
      load_en = 0;
      check("mid_pc16", PC, 16);
      rst_n = 0;
      tick();
      rst_n = 1;
      check("midrst_pc", PC, 0);
      check("midrst_running", running, 0);
      check("midrst_retired", retired, 0);
      check("midrst_instr", Instruction, 0);
      go();
      tick(6);
      check("keep_halted", halted, 1);
      check("keep_pc", PC, 20);
      check("keep_retired", retired, 5);

      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rst_n = ($urandom % 500) != 0;
         start = ($urandom % 20) == 0;
         load_en = ($urandom % 3) == 0;
         load_addr = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 32);
         load_data = rand_ins();
         Branch = 1'($urandom);
         UncondBranch = ($urandom % 4) == 0;
         Zero = 1'($urandom);
         tick();
      end
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
